// File: rtl/autolock_supervisor.sv
// Acquire/settle/hold/relock supervisor around AutoLock; registered outputs, one clk from input to state.
// Optional AUTOLOCK_SUPERVISOR_RAIL_FAULT_EN: PI underflow/overflow in SETTLE/LOCKED is treated as lock loss.
module autolock_supervisor #(
  parameter int DW = 16,
  parameter int TW = 32,
  parameter int RW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 clear_counts,
  input  logic                 update,
  input  logic signed [DW-1:0] discriminator,
  input  logic signed [DW-1:0] threshold,
  input  logic                 lock_engaged,
  input  logic                 scan_active,
  input  logic                 underflow,
  input  logic                 overflow,
  input  logic [TW-1:0]        settle_time,
  input  logic [TW-1:0]        holdoff_time,
  input  logic [RW-1:0]        max_relock,
  output logic                 autolock_enable,
  output logic [2:0]           state,
  output logic                 locked,
  output logic                 lock_lost,
  output logic [RW-1:0]        relock_count,
  output logic [TW-1:0]        locked_time
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SEARCH  = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_LOCKED  = 3'd3;
  localparam logic [2:0] S_HOLDOFF = 3'd4;
  localparam logic [2:0] S_FAULT   = 3'd5;

  logic [2:0]    state_next;
  logic [TW-1:0] settle_cnt, settle_cnt_next;
  logic [TW-1:0] hold_cnt, hold_cnt_next;
  logic          good, rail, lost_next, enter_holdoff;

  assign good = update && (discriminator >= threshold);

`ifdef AUTOLOCK_SUPERVISOR_RAIL_FAULT_EN
  assign rail = underflow | overflow;
`else
  logic rail_unused;
  assign rail_unused = underflow | overflow;
  assign rail = 1'b0;
`endif

  always_comb begin
    state_next      = state;
    settle_cnt_next = settle_cnt;
    hold_cnt_next   = hold_cnt;
    lost_next       = 1'b0;
    if (!run) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_next = S_SEARCH;
        S_SEARCH: begin
          if (lock_engaged) begin
            state_next      = S_SETTLE;
            settle_cnt_next = '0;
          end
        end
        S_SETTLE: begin
          if (rail || !lock_engaged || (update && !good)) begin
            state_next = S_HOLDOFF;
          end else if (settle_cnt >= settle_time) begin
            state_next = S_LOCKED;
          end else if (good) begin
            // settle_cnt < settle_time here, so the increment cannot wrap
            if (settle_cnt + TW'(1) >= settle_time) state_next = S_LOCKED;
            else settle_cnt_next = settle_cnt + TW'(1);
          end
        end
        S_LOCKED: begin
          if (rail || !lock_engaged || scan_active) begin
            state_next = S_HOLDOFF;
            lost_next  = 1'b1;
          end
        end
        S_HOLDOFF: begin
          // relock_count already holds the post-increment value on the first HOLDOFF cycle
          if (max_relock != '0 && relock_count >= max_relock) state_next = S_FAULT;
          else if (hold_cnt >= holdoff_time) state_next = S_SEARCH;
          else hold_cnt_next = hold_cnt + TW'(1);
        end
        S_FAULT: state_next = S_FAULT;
        default: state_next = S_IDLE;
      endcase
    end
    if (state != S_HOLDOFF && state_next == S_HOLDOFF) hold_cnt_next = TW'(1);
  end

  assign enter_holdoff = (state != S_HOLDOFF) && (state_next == S_HOLDOFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      autolock_enable <= 1'b0;
      locked          <= 1'b0;
      lock_lost       <= 1'b0;
      settle_cnt      <= '0;
      hold_cnt        <= '0;
      relock_count    <= '0;
      locked_time     <= '0;
    end else begin
      state           <= state_next;
      autolock_enable <= (state_next == S_SEARCH) || (state_next == S_SETTLE);
      locked          <= (state_next == S_LOCKED);
      lock_lost       <= lost_next;
      settle_cnt      <= settle_cnt_next;
      hold_cnt        <= hold_cnt_next;
      if (clear_counts) relock_count <= '0;
      else if (enter_holdoff && relock_count != '1) relock_count <= relock_count + RW'(1);
      if (clear_counts) locked_time <= '0;
      else if (state == S_LOCKED && update && locked_time != '1) locked_time <= locked_time + TW'(1);
    end
  end

endmodule

// File: tb/tb_autolock_supervisor.sv
// Directed bench for autolock_supervisor with a per-cycle behavioural model and literal spot checks.
module tb_autolock_supervisor;

  logic               clk, rst_n, run, clear_counts, update;
  logic signed [15:0] discriminator, threshold;
  logic               lock_engaged, scan_active, underflow, overflow;
  logic [31:0]        settle_time, holdoff_time;
  logic [7:0]         max_relock;
  logic               autolock_enable, locked, lock_lost;
  logic [2:0]         state;
  logic [7:0]         relock_count;
  logic [31:0]        locked_time;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 0;

  autolock_supervisor #(.DW(16), .TW(32), .RW(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .clear_counts(clear_counts), .update(update),
    .discriminator(discriminator), .threshold(threshold), .lock_engaged(lock_engaged),
    .scan_active(scan_active), .underflow(underflow), .overflow(overflow),
    .settle_time(settle_time), .holdoff_time(holdoff_time), .max_relock(max_relock),
    .autolock_enable(autolock_enable), .state(state), .locked(locked), .lock_lost(lock_lost),
    .relock_count(relock_count), .locked_time(locked_time)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int    m_state, m_rc, nxt;
  longint m_lt, m_goods, m_ho_left;
  bit    m_en, m_locked, m_lost, m_giveup, lost, is_good, rail;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_rc = 0; m_lt = 0; m_goods = 0; m_ho_left = 0;
      m_en = 0; m_locked = 0; m_lost = 0; m_giveup = 0;
    end else begin
      nxt = m_state;
      lost = 0;
      is_good = update && (int'(discriminator) >= int'(threshold));
      rail = 0;
`ifdef AUTOLOCK_SUPERVISOR_RAIL_FAULT_EN
      rail = underflow || overflow;
`endif
      if (m_state == 3 && update && m_lt < 64'hFFFF_FFFF) m_lt++;
      if (!run) nxt = 0;
      else case (m_state)
        0: nxt = 1;
        1: if (lock_engaged) begin nxt = 2; m_goods = 0; end
        2: begin
          if (rail || !lock_engaged || (update && !is_good)) nxt = 4;
          else begin
            if (is_good) m_goods++;
            if (m_goods >= longint'(settle_time)) nxt = 3;
          end
        end
        3: if (rail || !lock_engaged || scan_active) begin nxt = 4; lost = 1; end
        4: begin
          if (m_giveup) nxt = 5;
          else if (m_ho_left <= 1) nxt = 1;
          else m_ho_left--;
        end
        default: ;
      endcase
      if (nxt == 4 && m_state != 4) begin
        m_ho_left = (holdoff_time == 0) ? 1 : longint'(holdoff_time);
        m_rc = clear_counts ? 0 : ((m_rc < 255) ? m_rc + 1 : 255);
        m_giveup = (max_relock != 0) && (m_rc >= int'(max_relock));
      end else if (clear_counts) m_rc = 0;
      if (clear_counts) m_lt = 0;
      m_state = nxt;
      m_en = (nxt == 1) || (nxt == 2);
      m_locked = (nxt == 3);
      m_lost = lost;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_state", state, m_state);
      check("cyc_enable", autolock_enable, m_en);
      check("cyc_locked", locked, m_locked);
      check("cyc_lock_lost", lock_lost, m_lost);
      check("cyc_relock_count", relock_count, m_rc);
      check("cyc_locked_time", locked_time, m_lt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic signed [15:0] d);
    discriminator = d;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic wait_state(input string name, input logic [2:0] s, input int budget);
    int n;
    n = 0;
    while (state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, state, s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    int lowcnt;
    rst_n = 0; run = 0; clear_counts = 0; update = 0; discriminator = 0; threshold = 16'sd1000;
    lock_engaged = 0; scan_active = 0; underflow = 0; overflow = 0;
    settle_time = 4; holdoff_time = 10; max_relock = 0;
    cyc(3);
    check("reset_state", state, 3'd0);
    check("reset_enable", autolock_enable, 1'b0);
    check("reset_relock", relock_count, 8'd0);
    check("reset_locked_time", locked_time, 32'd0);
    rst_n = 1;
    cmp_en = 1;
    cyc(2);

    // acquire
    run = 1;
    cyc(1);
    check("acq_enable_after_run", autolock_enable, 1'b1);
    check("acq_search", state, 3'd1);
    lock_engaged = 1;
    cyc(1);
    check("acq_settle", state, 3'd2);
    for (int i = 0; i < 4; i++) begin
      strobe(16'sd12000);
      if (i < 3) check("acq_still_settle", state, 3'd2);
      cyc(1);
    end
    check("acq_locked_state", state, 3'd3);
    check("acq_locked_flag", locked, 1'b1);
    for (int i = 0; i < 3; i++) begin strobe(16'sd12000); cyc(1); end
    check("locked_time_3", locked_time, 32'd3);

    // loss and relock
    lock_engaged = 0;
    cyc(1);
    check("loss_holdoff", state, 3'd4);
    check("loss_pulse", lock_lost, 1'b1);
    check("loss_relock1", relock_count, 8'd1);
    lowcnt = 1;
    while (!autolock_enable && lowcnt < 50) begin
      cyc(1);
      if (!autolock_enable) lowcnt++;
    end
    check("holdoff_low_cycles", lowcnt, 10);
    check("holdoff_to_search", state, 3'd1);

    // settle failure at count 2
    lock_engaged = 1;
    cyc(1);
    strobe(16'sd12000);
    strobe(16'sd12000);
    strobe(16'sd100);
    check("settle_fail_holdoff", state, 3'd4);
    check("settle_fail_relock2", relock_count, 8'd2);
    check("settle_fail_no_pulse", lock_lost, 1'b0);
    wait_state("resettle", 3'd2, 40);

    // signed compare
    threshold = -16'sd20;
    strobe(-16'sd10);
    check("neg_good_stays", state, 3'd2);
    strobe(-16'sd30);
    check("neg_bad_holdoff", state, 3'd4);
    check("neg_relock3", relock_count, 8'd3);

    // give up after three failed settles
    clear_counts = 1;
    cyc(1);
    clear_counts = 0;
    check("clear_relock", relock_count, 8'd0);
    max_relock = 3;
    threshold = 16'sd1000;
    for (int i = 0; i < 3; i++) begin
      wait_state("giveup_settle", 3'd2, 40);
      strobe(16'sd100);
      check("giveup_holdoff", state, 3'd4);
    end
    wait_state("fault", 3'd5, 5);
    check("fault_enable", autolock_enable, 1'b0);
    check("fault_relock3", relock_count, 8'd3);
    cyc(5);
    check("fault_sticky", state, 3'd5);
    run = 0;
    cyc(1);
    check("idle_after_run0", state, 3'd0);
    cyc(3);
    check("idle_relock_held", relock_count, 8'd3);
    clear_counts = 1;
    cyc(1);
    clear_counts = 0;
    check("idle_relock_cleared", relock_count, 8'd0);

    // settle_time = 0, then scan_active loss
    max_relock = 0;
    settle_time = 0;
    run = 1;
    cyc(1);
    check("st0_search", state, 3'd1);
    cyc(1);
    check("st0_settle", state, 3'd2);
    cyc(1);
    check("st0_locked", state, 3'd3);
    strobe(16'sd5);
    scan_active = 1;
    cyc(1);
    scan_active = 0;
    check("scan_holdoff", state, 3'd4);
    check("scan_pulse", lock_lost, 1'b1);
    wait_state("relocked", 3'd3, 40);

    // rail fault
    overflow = 1;
    cyc(1);
    overflow = 0;
`ifdef AUTOLOCK_SUPERVISOR_RAIL_FAULT_EN
    check("rail_holdoff", state, 3'd4);
    check("rail_pulse", lock_lost, 1'b1);
`else
    check("rail_ignored", state, 3'd3);
    check("rail_no_pulse", lock_lost, 1'b0);
`endif

    // asynchronous reset mid-SETTLE
    run = 0;
    cyc(1);
    settle_time = 100;
    run = 1;
    wait_state("pre_reset_settle", 3'd2, 5);
    #2;
    rst_n = 0;
    #1;
    check("arst_state", state, 3'd0);
    check("arst_enable", autolock_enable, 1'b0);
    check("arst_locked", locked, 1'b0);
    check("arst_relock", relock_count, 8'd0);
    check("arst_locked_time", locked_time, 32'd0);
    cyc(2);
    rst_n = 1;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/autolock_supervisor.md
Name: autolock_supervisor

Overview:
- Drives the `enable` input of AutoLock and consumes its `enable_lock_out` / `scanEnable` outputs, closing the acquire/hold/relock loop around AutoLock.
- Qualifies an acquired lock over a settle window, declares loss, and counts relock attempts.
- Gives up after a programmable retry budget; exports lock status and lock-duration counters to the host register map.

Parameters:
- DW, 16, width of the discriminator and threshold words (two's complement).
- TW, 32, width of the settle/hold-off counters and the locked-time counter.
- RW, 8, width of the relock counter and the retry budget.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  host request to supervise; deasserting returns to IDLE.
- clear_counts  in  1  single-cycle pulse; zeroes relock_count and locked_time.
- update  in  1  sample strobe, same strobe that feeds AutoLock.
- discriminator  in  DW  signed lock-quality signal.
- threshold  in  DW  signed lock-quality threshold.
- lock_engaged  in  1  AutoLock enable_lock_out.
- scan_active  in  1  AutoLock scanEnable.
- underflow  in  1  PI core underflow.
- overflow  in  1  PI core overflow.
- settle_time  in  TW  number of update strobes the lock must persist before LOCKED.
- holdoff_time  in  TW  number of clk cycles autolock_enable stays low between attempts.
- max_relock  in  RW  retry budget; 0 means unlimited.
- autolock_enable  out  1  drives AutoLock enable.
- state  out  3  IDLE=0, SEARCH=1, SETTLE=2, LOCKED=3, HOLDOFF=4, FAULT=5.
- locked  out  1  high only in LOCKED.
- lock_lost  out  1  one-cycle pulse on the LOCKED->HOLDOFF transition.
- relock_count  out  RW  relock attempts; saturates at all-ones.
- locked_time  out  TW  update strobes spent in LOCKED; saturates.

Behaviour:
- Reset values: all outputs 0; state=IDLE; internal counters 0.
- Outputs are registered; state and autolock_enable change on the clk edge after the causing input is sampled.
- good = update && (discriminator >= threshold), signed compare.
- IDLE: autolock_enable=0. run=1 -> SEARCH.
- SEARCH: autolock_enable=1.
  - lock_engaged=1 -> SETTLE; settle counter loaded with 0.
- SETTLE: autolock_enable=1.
  - Each good strobe increments the settle counter.
  - A strobe that is not good -> HOLDOFF.
  - lock_engaged falls -> HOLDOFF.
  - Counter reaches settle_time -> LOCKED.
  - settle_time=0 -> LOCKED on the next cycle.
- LOCKED: locked=1. locked_time increments on every update strobe.
  - lock_engaged falls, or scan_active rises -> HOLDOFF, with lock_lost pulse.
  - A failing strobe alone does not leave LOCKED; AutoLock owns that decision.
- HOLDOFF: autolock_enable=0 for holdoff_time cycles (minimum 1).
  - On entry, relock_count increments.
  - If max_relock != 0 and the post-increment relock_count >= max_relock -> FAULT; else -> SEARCH on expiry.
- FAULT: autolock_enable=0; exits only on run=0 -> IDLE.
- run=0 in any state -> IDLE next cycle. autolock_enable drops that cycle. Counters are retained.
- clear_counts has priority over a same-cycle increment; the result is 0.
- Reset mid-operation returns everything to reset values immediately (asynchronous).

Optional Feature:
- Macro: AUTOLOCK_SUPERVISOR_RAIL_FAULT_EN.
- Defined: underflow or overflow high for one cycle in SETTLE or LOCKED forces HOLDOFF. From LOCKED this also pulses lock_lost. The regulator hitting a rail is treated as lock loss.
- Undefined: underflow/overflow are ignored (ports kept, unused).

Test Plan:
- Acquire: run=1, threshold=1000, settle_time=4. Raise lock_engaged, then give 4 strobes with discriminator=12000. Expect:
  - autolock_enable=1 one cycle after run;
  - state SEARCH->SETTLE->LOCKED;
  - locked=1 after the 4th strobe.
- Loss and relock: while LOCKED, drop lock_engaged with holdoff_time=10. Expect:
  - lock_lost pulse of 1 cycle;
  - relock_count=1;
  - autolock_enable low exactly 10 cycles, then SEARCH.
- Settle failure: in SETTLE at count 2, give a strobe with discriminator=100. Expect HOLDOFF, relock_count increments, no lock_lost pulse.
- Give up: max_relock=3, force 3 failed settles. Expect FAULT with autolock_enable=0. run=0 -> IDLE; relock_count holds 3 until clear_counts.
- Negative compare: threshold=-20, discriminator=-10 counts as good; discriminator=-30 does not (signed).
- Rail fault, both builds: with the macro, overflow=1 in LOCKED gives HOLDOFF plus lock_lost. Without the macro, state stays LOCKED. Finally assert rst_n=0 mid-SETTLE; all outputs are 0 asynchronously.
